// File: rtl/c7bexu_pkg.sv
// Shared types and constants for the c7bexu writeback path.
package c7bexu_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    // Register 0 is hardwired; writes to it are never queued.
    localparam logic [AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/c7bexu_wbq_lookup.sv
// Youngest-match search over the occupied region of the writeback queue.
module c7bexu_wbq_lookup
    import c7bexu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] ent_addr [DEPTH],
    input  logic [DW-1:0] ent_data [DEPTH],
    input  logic [PW-1:0] head,
    input  logic [PW:0]   count,
    input  logic [AW-1:0] lk_addr,
    output logic          hit,
    output logic [DW-1:0] data
);

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((PW+1)'(i) < count) && (lk_addr != AW'(ZERO_REG)) &&
                (ent_addr[head + PW'(i)] == lk_addr)) begin
                hit  = 1'b1;
                data = ent_data[head + PW'(i)];
            end
        end
    end

endmodule

// File: rtl/c7bexu_wbq.sv
// Dual-lane writeback queue feeding the register file's two write ports,
// with pending-value lookup for decode forwarding.
module c7bexu_wbq
    import c7bexu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in0_valid,
    input  logic [AW-1:0] in0_addr,
    input  logic [DW-1:0] in0_data,
    input  logic          in1_valid,
    input  logic [AW-1:0] in1_addr,
    input  logic [DW-1:0] in1_data,
    output logic          in_ready,
    input  logic          flush,
    input  logic          hold,
    output logic          wen1,
    output logic [AW-1:0] waddr1,
    output logic [DW-1:0] wdata1,
    output logic          wen2,
    output logic [AW-1:0] waddr2,
    output logic [DW-1:0] wdata2,
    input  logic [AW-1:0] lk0_addr,
    input  logic [AW-1:0] lk1_addr,
    output logic          lk0_hit,
    output logic [DW-1:0] lk0_data,
    output logic          lk1_hit,
    output logic [DW-1:0] lk1_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          keep0;
    logic          keep1;
    logic          enq_go;
    logic [CW-1:0] enq_n;
    logic [CW-1:0] deq_n;
    logic [PW-1:0] head1;

    // Readiness ignores any slots a same-cycle drain would free.
    always_comb begin
        in_ready = (count <= CW'(DEPTH - 2));
        keep0    = in0_valid && (in0_addr != AW'(ZERO_REG));
        keep1    = in1_valid && (in1_addr != AW'(ZERO_REG));
        enq_go   = in_ready && !flush;
        enq_n    = enq_go ? (CW'(keep0) + CW'(keep1)) : '0;
        head1    = head + PW'(1);

        wen1   = !hold && (count >= CW'(1));
        wen2   = !hold && (count >= CW'(2));
        waddr1 = wen1 ? addr_q[head]  : '0;
        wdata1 = wen1 ? data_q[head]  : '0;
        waddr2 = wen2 ? addr_q[head1] : '0;
        wdata2 = wen2 ? data_q[head1] : '0;
        deq_n  = flush ? '0 : (CW'(wen1) + CW'(wen2));
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(deq_n);
            tail  <= tail + PW'(enq_n);
            count <= count + enq_n - deq_n;
        end
    end

    // Surviving lanes are packed in order; a lone lane 1 lands at tail.
    always_ff @(posedge clk) begin
        if (rst_n && enq_go) begin
            if (keep0) begin
                addr_q[tail] <= in0_addr;
                data_q[tail] <= in0_data;
            end
            if (keep1) begin
                addr_q[keep0 ? tail + PW'(1) : tail] <= in1_addr;
                data_q[keep0 ? tail + PW'(1) : tail] <= in1_data;
            end
        end
    end

    c7bexu_wbq_lookup #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_lk0 (
        .ent_addr (addr_q),
        .ent_data (data_q),
        .head     (head),
        .count    (count),
        .lk_addr  (lk0_addr),
        .hit      (lk0_hit),
        .data     (lk0_data)
    );

    c7bexu_wbq_lookup #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_lk1 (
        .ent_addr (addr_q),
        .ent_data (data_q),
        .head     (head),
        .count    (count),
        .lk_addr  (lk1_addr),
        .hit      (lk1_hit),
        .data     (lk1_data)
    );

endmodule

// File: tb/tb_c7bexu_wbq.sv
// Bench for c7bexu_wbq: queue-based reference model plus directed literal checks.
module tb_c7bexu_wbq;
    import c7bexu_pkg::*;

    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          in0_valid, in1_valid;
    logic [AW-1:0] in0_addr, in1_addr;
    logic [DW-1:0] in0_data, in1_data;
    logic          in_ready;
    logic          flush, hold;
    logic          wen1, wen2;
    logic [AW-1:0] waddr1, waddr2;
    logic [DW-1:0] wdata1, wdata2;
    logic [AW-1:0] lk0_addr, lk1_addr;
    logic          lk0_hit, lk1_hit;
    logic [DW-1:0] lk0_data, lk1_data;

    c7bexu_wbq #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_addr(in0_addr), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_addr(in1_addr), .in1_data(in1_data),
        .in_ready(in_ready), .flush(flush), .hold(hold),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .wen2(wen2), .waddr2(waddr2), .wdata2(wdata2),
        .lk0_addr(lk0_addr), .lk1_addr(lk1_addr),
        .lk0_hit(lk0_hit), .lk0_data(lk0_data),
        .lk1_hit(lk1_hit), .lk1_data(lk1_data)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    wbq_entry_t model_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_look(input logic [AW-1:0] a, output logic h,
                                       output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        if (a != '0) begin
            for (int i = model_q.size() - 1; i >= 0; i--) begin
                if (model_q[i].addr == a) begin
                    h = 1'b1;
                    d = model_q[i].data;
                    break;
                end
            end
        end
    endfunction

    // compare process: check outputs against the model, then advance the model
    always @(negedge clk) begin
        int            n;
        logic          e_w1, e_w2, e_rdy, h;
        logic [AW-1:0] e_a1, e_a2;
        logic [DW-1:0] e_d1, e_d2, d;
        n     = model_q.size();
        e_rdy = (DEPTH - n) >= 2;
        e_w1  = !hold && (n >= 1);
        e_w2  = !hold && (n >= 2);
        e_a1 = '0; e_d1 = '0; e_a2 = '0; e_d2 = '0;
        if (e_w1) begin e_a1 = model_q[0].addr; e_d1 = model_q[0].data; end
        if (e_w2) begin e_a2 = model_q[1].addr; e_d2 = model_q[1].data; end
        if (chk_en) begin
            chk("m_in_ready", in_ready, e_rdy);
            chk("m_wen1", wen1, e_w1);
            chk("m_waddr1", waddr1, e_a1);
            chk("m_wdata1", wdata1, e_d1);
            chk("m_wen2", wen2, e_w2);
            chk("m_waddr2", waddr2, e_a2);
            chk("m_wdata2", wdata2, e_d2);
            model_look(lk0_addr, h, d);
            chk("m_lk0_hit", lk0_hit, h);
            chk("m_lk0_data", lk0_data, d);
            model_look(lk1_addr, h, d);
            chk("m_lk1_hit", lk1_hit, h);
            chk("m_lk1_data", lk1_data, d);
        end
        if (!rst_n || flush) begin
            model_q.delete();
        end else begin
            if (e_w2) void'(model_q.pop_front());
            if (e_w1) void'(model_q.pop_front());
            if (e_rdy) begin
                if (in0_valid && in0_addr != '0)
                    model_q.push_back(wbq_entry_t'{addr: in0_addr, data: in0_data});
                if (in1_valid && in1_addr != '0)
                    model_q.push_back(wbq_entry_t'{addr: in1_addr, data: in1_data});
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
    endtask

    task automatic idle();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic pair(input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        in0_valid = 1'b1; in0_addr = a0; in0_data = d0;
        in1_valid = 1'b1; in1_addr = a1; in1_data = d1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
        in0_addr = '0; in0_data = '0; in1_addr = '0; in1_data = '0;
        idle();
        lk0_addr = 5; lk1_addr = 0;

        // reset, then first pair
        step(); step();
        rst_n = 1'b1;
        pair(5, 32'h11, 6, 32'h22);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wen1", wen1, 0);
        chk("rst_wen2", wen2, 0);
        chk("rst_lk0_hit", lk0_hit, 0);
        step();
        idle();
        @(negedge clk);
        chk("p1_wen1", wen1, 1);
        chk("p1_waddr1", waddr1, 5);
        chk("p1_wdata1", wdata1, 32'h11);
        chk("p1_wen2", wen2, 1);
        chk("p1_waddr2", waddr2, 6);
        chk("p1_wdata2", wdata2, 32'h22);
        chk("p1_lk0_data", lk0_data, 32'h11);

        // zero-register lane is dropped
        step();
        pair(0, 32'hAA, 7, 32'h77);
        step();
        idle();
        @(negedge clk);
        chk("z_wen1", wen1, 1);
        chk("z_waddr1", waddr1, 7);
        chk("z_wdata1", wdata1, 32'h77);
        chk("z_wen2", wen2, 0);
        step();
        @(negedge clk);
        chk("z_empty_wen1", wen1, 0);

        // backpressure
        step();
        hold = 1'b1;
        pair(1, 32'hA1, 2, 32'hA2);
        step();
        pair(3, 32'hA3, 4, 32'hA4);
        step();
        pair(8, 32'h88, 10, 32'h99);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_wen1", wen1, 0);
        step();
        idle();
        hold = 1'b0;
        @(negedge clk);
        chk("bp_d1_waddr1", waddr1, 1);
        chk("bp_d1_waddr2", waddr2, 2);
        chk("bp_d1_wdata2", wdata2, 32'hA2);
        step();
        @(negedge clk);
        chk("bp_d2_waddr1", waddr1, 3);
        chk("bp_d2_waddr2", waddr2, 4);
        step();
        @(negedge clk);
        chk("bp_ignored_wen1", wen1, 0);

        // lookup picks the youngest match
        step();
        hold = 1'b1;
        pair(9, 32'h1, 9, 32'h2);
        lk0_addr = 9; lk1_addr = 0;
        step();
        idle();
        @(negedge clk);
        chk("lk_hit0", lk0_hit, 1);
        chk("lk_data0", lk0_data, 32'h2);
        chk("lk_hit1", lk1_hit, 0);
        chk("lk_data1", lk1_data, 0);
        step();
        hold = 1'b0;
        step(); step();

        // sustained 2-in/2-out across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            pair(AW'($urandom_range(1, 31)), $urandom, AW'($urandom_range(1, 31)), $urandom);
            lk0_addr = in0_addr; lk1_addr = in1_addr;
            step();
        end
        idle();
        step(); step();

        // flush mid-operation, then reset mid-operation
        for (int k = 0; k < 2; k++) begin
            hold = 1'b1;
            pair(11, 32'hB1, 12, 32'hB2);
            step();
            pair(13, 32'hB3, 0, 32'h0);
            in1_valid = 1'b0;
            step();
            idle();
            lk0_addr = 13;
            @(negedge clk);
            chk("fl_in_ready", in_ready, 0);
            step();
            hold = 1'b0;
            if (k == 0) flush = 1'b1;
            else rst_n = 1'b0;
            @(negedge clk);
            chk("fl_preflush_wen1", wen1, 1);
            chk("fl_preflush_waddr1", waddr1, 11);
            step();
            flush = 1'b0;
            rst_n = 1'b1;
            @(negedge clk);
            chk("fl_wen1", wen1, 0);
            chk("fl_lk0_hit", lk0_hit, 0);
            chk("fl_in_ready", in_ready, 1);
            step();
        end

        // randomized mix
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            hold      = ($urandom_range(0, 3) == 0);
            in0_valid = $urandom_range(0, 1);
            in1_valid = $urandom_range(0, 1);
            in0_addr  = AW'($urandom_range(0, 7));
            in1_addr  = AW'($urandom_range(0, 7));
            in0_data  = $urandom;
            in1_data  = $urandom;
            lk0_addr  = AW'($urandom_range(0, 7));
            lk1_addr  = AW'($urandom_range(0, 7));
            step();
        end
        rst_n = 1'b1; flush = 1'b0; hold = 1'b0;
        idle();
        step(); step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c7bexu_wbq.md
# c7bexu_wbq

Dual-lane writeback queue that sits directly upstream of the c7bexu register file. It accepts up to two completed results per cycle from the execute stage in program order, buffers them, and drains up to two per cycle onto the register file's two write ports. Lane 0 is always the older write and lane 1 the younger. A lookup port returns the youngest pending value for any register still queued, so decode can forward data that has not yet reached the register file.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, at least 2
- DW, 32: data width
- AW, 5: register address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- in0_valid / in0_addr / in0_data  in  1/AW/DW  older result
- in1_valid / in1_addr / in1_data  in  1/AW/DW  younger result
- in_ready  out  1  both lanes may be presented this cycle
- flush  in  1  discard all queued entries
- hold  in  1  suppress draining this cycle
- wen1 / waddr1 / wdata1  out  1/AW/DW  older write to the register file
- wen2 / waddr2 / wdata2  out  1/AW/DW  younger write to the register file
- lk0_addr / lk1_addr  in  AW  lookup addresses
- lk0_hit / lk0_data, lk1_hit / lk1_data  out  1/DW  pending-value lookup result

## Operation
- Storage is a circular buffer with head pointer, tail pointer and a count register of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- in_ready = (DEPTH − count) ≥ 2. It is computed from the registered count only; slots freed by a same-cycle drain do not count.
- Enqueue fires when in_ready is high and a lane is valid:
  - Lanes with addr==0 are dropped and never stored.
  - Surviving lanes are compacted in order: lane 0 goes to tail, lane 1 to tail+1. If only lane 1 survives, it goes to tail.
  - tail advances by the number of stored lanes.
  - If in_ready is low, both lanes are ignored; the upstream stage must hold its values.
- Drain runs when hold is low:
  - wen1 = count≥1; waddr1/wdata1 come from the head entry.
  - wen2 = count≥2; waddr2/wdata2 come from head+1.
  - head advances by wen1+wen2.
  - A same-address pair is still emitted on both ports; the register file gives port 2 priority, which preserves program order.
- Write outputs are driven combinationally from registered entries. When a wen is low, its waddr and wdata are 0.
- count_next = count + enq_n − deq_n. Enqueue and drain in the same cycle are legal.
- Lookup (combinational, registered entries only):
  - Search all valid entries between head and tail.
  - hit = any match with lkX_addr ≠ 0.
  - data = youngest matching entry (closest to tail); 0 on miss.
  - Entries being enqueued in the current cycle are not visible.
- flush: head, tail and count are cleared at the clock edge. Enqueue and drain in that cycle are ignored, but the wen outputs still reflect pre-flush state during that cycle.
- Reset: head=tail=count=0, in_ready=1, every wen/hit=0, every addr/data output=0. Reset asserted mid-operation discards all entries at the edge.

## Timing
- Enqueue-to-write latency is 1 cycle: an entry stored at edge N appears on wen1 or wen2 during cycle N+1.
- Lookup reflects entries stored at or before the previous edge, with 0-cycle combinational latency.
- Sustained throughput is 2 writes per cycle with in_ready continuously high, provided DEPTH≥4 and hold is low.
- With DEPTH=4 and count=3, in_ready is low even though a drain of 2 is occurring in that cycle.

## Structure
- Shared package c7bexu_pkg holds DW, AW, the ZERO_REG constant and the wbq_entry_t typedef {addr, data}.
- Single sub-module c7bexu_wbq_lookup: the youngest-match priority search, instantiated once per lookup port.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → in_ready=1, wen1=wen2=0, lk0_hit=0. Then enqueue (5, 0x11) and (6, 0x22) → next cycle wen1=1 with waddr1=5, wdata1=0x11, and wen2=1 with waddr2=6, wdata2=0x22.
- Zero register: enqueue lane0 (0, 0xAA), lane1 (7, 0x77) → only waddr1=7, wdata1=0x77 appears next cycle; wen2=0 and count=0 afterwards.
- Backpressure: hold=1, enqueue 2 pairs → count=4, in_ready=0. Present a third pair → it is ignored. Release hold → 2 cycles of dual writes in the original order.
- Lookup: queue (9, 0x1), (9, 0x2) with hold=1 → lk0_addr=9 gives hit=1, data=0x2. lk1_addr=0 gives hit=0, data=0.
- Wrap plus simultaneous events: run 10 cycles of 2-in/2-out with varied addresses → the register-file write stream exactly matches the enqueue order across the pointer wrap.
- Flush and reset mid-operation: count=3, assert flush → next cycle count=0, wen1=0, lookup misses. Repeat the same check with rst_n=0 in place of flush.
